codec_tx_if: RTL

Serial transmit side of the audio codec interface: the parallel-to-serial counterpart of the codec receive path. Accepts 24-bit left/right sample pairs from the processing core (top_level float datapath, after conversion to fixed point) over a valid/ready handshake. Double-buffers them and shifts them out MSB-first in I2S format. Generates the codec bit clock and word-select from the system clock.

---
 rtl/codec_tx_if.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/codec_tx_if.sv
// codec_tx_if: I2S serial transmitter for 24-bit stereo samples.
// A valid/ready port feeds a one-deep holding register. The holding register
// feeds an active register that is shifted out MSB-first.
// BCLK and LRCLK are derived from clk by a half-period divider.
module codec_tx_if #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned DATA_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] in_left,
   input  logic [DATA_BITS-1:0] in_right,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 codec_bclk,
   output logic                 codec_lrclk,
   output logic                 codec_sdata,
   output logic                 underrun,
   output logic                 frame_start
);

   localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
   localparam logic [DATA_BITS-1:0] MSB_ONE = {1'b1, {(DATA_BITS-1){1'b0}}};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_BITS-1:0] left;
      logic [DATA_BITS-1:0] right;
   } pair_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               bclk_q, bclk_d;
   logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
   logic               lrclk_q, lrclk_d;
   logic               sdata_q, sdata_d;
   pair_t              hold_q, hold_d;
   pair_t              act_q, act_d;
   logic               ready_q, ready_d;
   logic               underrun_q, underrun_d;
   logic               fstart_q, fstart_d;

   pair_t              in_pair_c;
   logic               accept_c;
   logic               div_tc_c;
   logic               fall_c;
   logic               wrap_c;
   logic [BIT_W-1:0]   bitcnt_inc_c;
   logic               slot_right_c;
   logic [BIT_W-1:0]   slot_pos_c;
   logic [DATA_BITS-1:0] sample_c;
   logic [DATA_BITS-1:0] bit_mask_c;
   logic               data_bit_c;

   assign in_pair_c = {in_left, in_right};
   assign accept_c  = in_valid && ready_q;
   assign div_tc_c  = (div_q == DIV_W'(CLK_DIV - 1));
   assign fall_c    = (state_q == RUN) && div_tc_c && bclk_q;
   assign wrap_c    = fall_c && (bitcnt_q == BIT_W'(FRAME_BITS - 1));

   // Bit position and serial data value that take effect on the next falling tick
   always_comb begin
      bitcnt_inc_c = wrap_c ? '0 : (bitcnt_q + BIT_W'(1));
      slot_right_c = (bitcnt_inc_c >= BIT_W'(SLOT_BITS));
      slot_pos_c   = slot_right_c ? (bitcnt_inc_c - BIT_W'(SLOT_BITS)) : bitcnt_inc_c;
      sample_c     = slot_right_c ? act_q.right : act_q.left;
      bit_mask_c   = MSB_ONE >> (slot_pos_c - BIT_W'(1));
      data_bit_c   = 1'b0;
      if ((slot_pos_c != '0) && (slot_pos_c <= BIT_W'(DATA_BITS))) begin
         data_bit_c = |(sample_c & bit_mask_c);
      end
   end

   // Next-state: start-up load, BCLK divider, bit counter and frame-boundary buffer swap
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bclk_d     = bclk_q;
      bitcnt_d   = bitcnt_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      hold_d     = hold_q;
      act_d      = act_q;
      ready_d    = ready_q;
      underrun_d = 1'b0;
      fstart_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // First pair skips the holding register and starts the first frame
            if (accept_c) begin
               act_d    = in_pair_c;
               state_d  = RUN;
               div_d    = '0;
               bclk_d   = 1'b0;
               bitcnt_d = '0;
               lrclk_d  = 1'b0;
               sdata_d  = 1'b0;
               fstart_d = 1'b1;
            end
         end

         RUN: begin
            if (div_tc_c) begin
               div_d  = '0;
               bclk_d = ~bclk_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end

            if (fall_c) begin
               bitcnt_d = bitcnt_inc_c;
               lrclk_d  = slot_right_c;
               sdata_d  = data_bit_c;
            end

            if (wrap_c) begin
               fstart_d = 1'b1;
               if (!ready_q) begin
                  act_d   = hold_q;
                  ready_d = 1'b1;
               end else if (in_valid) begin
                  act_d = in_pair_c;
               end else begin
                  act_d      = '0;
                  underrun_d = 1'b1;
               end
            end else if (accept_c) begin
               hold_d  = in_pair_c;
               ready_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bclk_q     <= 1'b0;
         bitcnt_q   <= '0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         hold_q     <= '0;
         act_q      <= '0;
         ready_q    <= 1'b1;
         underrun_q <= 1'b0;
         fstart_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         bitcnt_q   <= bitcnt_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         hold_q     <= hold_d;
         act_q      <= act_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
         fstart_q   <= fstart_d;
      end
   end

   assign in_ready    = ready_q;
   assign codec_bclk  = bclk_q;
   assign codec_lrclk = lrclk_q;
   assign codec_sdata = sdata_q;
   assign underrun    = underrun_q;
   assign frame_start = fstart_q;

endmodule
